mouse_quad_decoder: RTL and testbench

MOUSE_QUAD_DECODER -- requirements
Module: mouse_quad_decoder

---
 rtl/mouse_dec_pkg.sv | 31 +++
 rtl/mouse_quad_decoder_quad_axis.sv | 83 ++++++++
 rtl/mouse_quad_decoder.sv | 81 ++++++++
 tb/tb_mouse_quad_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_dec_pkg.sv
// rtl/mouse_dec_pkg.sv - shared constants, step type and phase helper for the quadrature mouse decoder
package mouse_dec_pkg;

  typedef logic signed [2:0] step_t;

  localparam int ST_LEFT  = 0;
  localparam int ST_RIGHT = 1;
  localparam int ST_ONE   = 3;
  localparam int ST_XSIGN = 4;
  localparam int ST_YSIGN = 5;
  localparam int ST_XOVF  = 6;
  localparam int ST_YOVF  = 7;

  localparam int PKT_STATUS_LSB = 0;
  localparam int PKT_X_LSB      = 8;
  localparam int PKT_Y_LSB      = 16;
  localparam int PKT_TOGGLE     = 24;

  localparam logic [24:0] PKT_RESET = 25'h0000008;

  // Position of a phase along the forward sequence 00->10->11->01.
  function automatic logic [1:0] phase_pos(input logic [1:0] ph);
    case (ph)
      2'b00:   phase_pos = 2'd0;
      2'b10:   phase_pos = 2'd1;
      2'b11:   phase_pos = 2'd2;
      default: phase_pos = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mouse_quad_decoder_quad_axis.sv
// rtl/mouse_quad_decoder_quad_axis.sv - one axis: phase compare, direction memory, saturating accumulator
// Double-step recovery enabled by MOUSE_DEC_DOUBLESTEP_EN.
module quad_axis
  import mouse_dec_pkg::*;
#(
  parameter bit Y_INV = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] phase,
  input  logic       load,
  output logic [8:0] acc,
  output logic       ovf
);

  logic [1:0]        prev_q, prev_d;
  logic signed [8:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        delta;
  logic signed [9:0] sum;
  step_t             step;
`ifdef MOUSE_DEC_DOUBLESTEP_EN
  logic [1:0]        dir_q, dir_d;
`endif

  always_comb begin
    prev_d = phase;
    step   = '0;
    delta  = phase_pos(phase) - phase_pos(prev_q);
`ifdef MOUSE_DEC_DOUBLESTEP_EN
    dir_d  = dir_q;
`endif
    case (delta)
      2'd1: step = Y_INV ? -3'sd1 :  3'sd1;
      2'd3: step = Y_INV ?  3'sd1 : -3'sd1;
`ifdef MOUSE_DEC_DOUBLESTEP_EN
      // dir_q: 01 = last single step positive, 11 = negative, 00 = none yet
      2'd2: step = (dir_q == 2'b01) ? 3'sd2 : (dir_q == 2'b11) ? -3'sd2 : 3'sd0;
`endif
      default: step = '0;
    endcase
`ifdef MOUSE_DEC_DOUBLESTEP_EN
    if (delta == 2'd1 || delta == 2'd3) dir_d = step[2] ? 2'b11 : 2'b01;
`endif

    sum = {acc_q[8], acc_q} + {{7{step[2]}}, step};
    if (load) begin
      acc_d = {{6{step[2]}}, step};
      ovf_d = 1'b0;
    end else if (sum > 10'sd255) begin
      acc_d = 9'sd255;
      ovf_d = 1'b1;
    end else if (sum < -10'sd256) begin
      acc_d = 9'h100;
      ovf_d = 1'b1;
    end else begin
      acc_d = sum[8:0];
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
`ifdef MOUSE_DEC_DOUBLESTEP_EN
      dir_q  <= '0;
`endif
    end else begin
      prev_q <= prev_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
`ifdef MOUSE_DEC_DOUBLESTEP_EN
      dir_q  <= dir_d;
`endif
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/mouse_quad_decoder.sv
// rtl/mouse_quad_decoder.sv - Atari quadrature mouse to PS/2-style packet decoder
// Optional double-step recovery: MOUSE_DEC_DOUBLESTEP_EN (handled inside quad_axis).
module mouse_quad_decoder
  import mouse_dec_pkg::*;
#(
  parameter int PKT_INTERVAL = 16384
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  mouse_atari,
  output logic [24:0] ps2_mouse
);

  logic [5:0]  sync1_q, sync1_d;
  logic [5:0]  sync2_q, sync2_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  last_btn_q, last_btn_d;
  logic [24:0] pkt_q, pkt_d;
  logic [8:0]  acc_x, acc_y;
  logic        ovf_x, ovf_y;
  logic        expired, emit;
  logic [1:0]  btn;
  logic [7:0]  status;

  assign btn     = sync2_q[5:4];
  assign expired = (cnt_q == 16'(PKT_INTERVAL));

  quad_axis #(.Y_INV(1'b0)) u_x (
    .clk(clk), .reset_n(reset_n), .phase(sync2_q[1:0]), .load(emit), .acc(acc_x), .ovf(ovf_x)
  );

  quad_axis #(.Y_INV(1'b1)) u_y (
    .clk(clk), .reset_n(reset_n), .phase(sync2_q[3:2]), .load(emit), .acc(acc_y), .ovf(ovf_y)
  );

  always_comb begin
    sync1_d    = mouse_atari;
    sync2_d    = sync1_q;
    cnt_d      = expired ? cnt_q : cnt_q + 16'd1;
    last_btn_d = last_btn_q;
    pkt_d      = pkt_q;
    emit       = expired && ((acc_x != '0) || (acc_y != '0) || (btn != last_btn_q));

    status           = '0;
    status[ST_LEFT]  = btn[0];
    status[ST_RIGHT] = btn[1];
    status[ST_ONE]   = 1'b1;
    status[ST_XSIGN] = acc_x[8];
    status[ST_YSIGN] = acc_y[8];
    status[ST_XOVF]  = ovf_x;
    status[ST_YOVF]  = ovf_y;

    if (emit) begin
      cnt_d      = '0;
      last_btn_d = btn;
      pkt_d[PKT_TOGGLE]                     = ~pkt_q[PKT_TOGGLE];
      pkt_d[PKT_Y_LSB +: 8]                 = acc_y[7:0];
      pkt_d[PKT_X_LSB +: 8]                 = acc_x[7:0];
      pkt_d[PKT_STATUS_LSB +: 8]            = status;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cnt_q      <= '0;
      last_btn_q <= '0;
      pkt_q      <= PKT_RESET;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      last_btn_q <= last_btn_d;
      pkt_q      <= pkt_d;
    end
  end

  assign ps2_mouse = pkt_q;

endmodule

// File: tb/tb_mouse_quad_decoder.sv
// tb/tb_mouse_quad_decoder.sv - table-driven scoreboard bench for mouse_quad_decoder
module tb_mouse_quad_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  atari = '0;
  logic [5:0]  atari_l = '0;
  logic [24:0] ps2;
  logic [24:0] ps2_l;

  int errors = 0;
  int checks = 0;

  logic [23:0] exp_q[$];
  logic [23:0] exp_l[$];
  logic        prev_tog = 1'b0;
  logic        prev_tog_l = 1'b0;

  logic [1:0] x_ph = '0, y_ph = '0, btn = '0;

  typedef struct {
    string       name;
    int          fx;
    int          fy;
    logic [1:0]  b;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[7];

  mouse_quad_decoder #(.PKT_INTERVAL(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .mouse_atari(atari), .ps2_mouse(ps2)
  );

  mouse_quad_decoder #(.PKT_INTERVAL(700)) u_long (
    .clk(clk), .reset_n(reset_n), .mouse_atari(atari_l), .ps2_mouse(ps2_l)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset_n) prev_tog = ps2[24];
    else if (ps2[24] != prev_tog) begin
      prev_tog = ps2[24];
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_packet got=%h", ps2);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if (ps2[23:0] !== e) begin
          errors++;
          $display("FAIL packet got=%h want=%h", ps2[23:0], e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) prev_tog_l = ps2_l[24];
    else if (ps2_l[24] != prev_tog_l) begin
      prev_tog_l = ps2_l[24];
      checks++;
      if (exp_l.size() == 0) begin
        errors++;
        $display("FAIL unexpected_long_packet got=%h", ps2_l);
      end else begin
        logic [23:0] e;
        e = exp_l.pop_front();
        if (ps2_l[23:0] !== e) begin
          errors++;
          $display("FAIL long_packet got=%h want=%h", ps2_l[23:0], e);
        end
      end
    end
  end

  function automatic logic [1:0] adv(input logic [1:0] ph, input bit fwd);
    case (ph)
      2'b00:   adv = fwd ? 2'b10 : 2'b01;
      2'b10:   adv = fwd ? 2'b11 : 2'b00;
      2'b11:   adv = fwd ? 2'b01 : 2'b10;
      default: adv = fwd ? 2'b00 : 2'b11;
    endcase
  endfunction

  task automatic drive();
    atari = {btn, y_ph, x_ph};
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    x_ph = '0; y_ph = '0; btn = '0;
    atari = '0; atari_l = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic apply_steps(input int fx, input int fy);
    int ax, ay, n;
    ax = (fx < 0) ? -fx : fx;
    ay = (fy < 0) ? -fy : fy;
    n  = (ax > ay) ? ax : ay;
    for (int i = 0; i < n; i++) begin
      if (i < ax) x_ph = adv(x_ph, fx > 0);
      if (i < ay) y_ph = adv(y_ph, fy > 0);
      drive();
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input bit long_q, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((long_q ? exp_l.size() : exp_q.size()) == 0) break;
      @(posedge clk);
    end
    checks++;
    if ((long_q ? exp_l.size() : exp_q.size()) != 0) begin
      errors++;
      $display("FAIL %s timeout pending=%0d want=0", name, long_q ? exp_l.size() : exp_q.size());
      if (long_q) exp_l.delete(); else exp_q.delete();
    end
  endtask

  task automatic expect_idle(input string name, input int cycles);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ps2 !== 25'h0000008) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s got=%h want=0000008", name, ps2);
    end
  endtask

  initial begin
    tbl[0] = '{"x_plus5",   5,  0, 2'b00, 24'h00_05_08};
    tbl[1] = '{"y_three",   0,  3, 2'b00, 24'hFD_00_28};
    tbl[2] = '{"x_minus3", -3,  0, 2'b00, 24'h00_FD_18};
    tbl[3] = '{"xy_mix",    2, -4, 2'b00, 24'h04_02_08};
    tbl[4] = '{"right_btn", 0,  0, 2'b10, 24'h00_00_0A};
    tbl[5] = '{"left_btn",  0,  0, 2'b01, 24'h00_00_09};
    tbl[6] = '{"left_x1",   1,  0, 2'b01, 24'h00_01_09};

    repeat (2) @(negedge clk);
    checks++;
    if (ps2 !== 25'h0000008 || ps2_l !== 25'h0000008) begin
      errors++;
      $display("FAIL reset_value got=%h want=0000008", ps2);
    end
    #1 reset_n = 1'b1;
    expect_idle("idle_100", 100);

    foreach (tbl[k]) begin
      do_reset();
      btn = tbl[k].b;
      drive();
      exp_q.push_back(tbl[k].exp);
      apply_steps(tbl[k].fx, tbl[k].fy);
      wait_drain(tbl[k].name, 1'b0, 60);
      repeat (30) @(posedge clk);
    end

    // Press then release with no reset in between: second packet only reports the release.
    do_reset();
    btn = 2'b01; drive();
    exp_q.push_back(24'h00_00_09);
    wait_drain("press", 1'b0, 60);
    #1 btn = 2'b00; drive();
    exp_q.push_back(24'h00_00_08);
    wait_drain("release", 1'b0, 60);
    repeat (30) @(posedge clk);

    // Deltas pending at reset must vanish.
    do_reset();
    apply_steps(3, 0);
    @(posedge clk); #1;
    reset_n = 1'b0; x_ph = '0; atari = '0;
    @(negedge clk);
    checks++;
    if (ps2 !== 25'h0000008) begin
      errors++;
      $display("FAIL mid_reset got=%h want=0000008", ps2);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    expect_idle("after_mid_reset", 60);

    // Double step with no prior single step contributes nothing.
    do_reset();
    x_ph = 2'b11; drive();
    expect_idle("double_no_prior", 60);

    // One +step then a both-bits jump.
    do_reset();
    x_ph = 2'b10; drive();
    repeat (2) @(posedge clk); #1;
    x_ph = 2'b01; drive();
`ifdef MOUSE_DEC_DOUBLESTEP_EN
    exp_q.push_back(24'h00_03_08);
`else
    exp_q.push_back(24'h00_01_08);
`endif
    wait_drain("double_step", 1'b0, 60);
    repeat (30) @(posedge clk);

    // Saturation on the long-interval instance.
    do_reset();
    exp_l.push_back(24'h00_00_58);
    for (int i = 0; i < 300; i++) begin
      x_ph = adv(x_ph, 1'b0);
      atari_l = {2'b00, 2'b00, x_ph};
      @(posedge clk); #1;
    end
    wait_drain("saturate", 1'b1, 800);
    for (int i = 0; i < 2; i++) begin
      x_ph = adv(x_ph, 1'b1);
      atari_l = {2'b00, 2'b00, x_ph};
      @(posedge clk); #1;
    end
    exp_l.push_back(24'h00_02_08);
    wait_drain("ovf_cleared", 1'b1, 800);
    repeat (20) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
